mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer for the single shared instruction/data memory of the multi-cycle CPU. It accepts requests from three requesters: instruction fetch (ifu), load/store (lsu) and a debug/program loader (dbg). It grants one requester at a time and drives the memory's Address/Write_data/MemRead/MemWrite pins for exactly one access cycle. It returns read data through a registered response. It sits between the CPU control unit, the debug loader and the memory block.

## Interface
- ADDR_W, 32, address width of all ports and of mem_addr
- DATA_W, 32, data width of wdata/rdata paths
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- ifu_req  in  1  fetch request; held until ifu_ack
- ifu_addr  in  ADDR_W  fetch byte address; stable while ifu_req
- lsu_req  in  1  load/store request; held until lsu_ack
- lsu_we  in  1  1 = store, 0 = load
- lsu_addr  in  ADDR_W  load/store byte address
- lsu_wdata  in  DATA_W  store data
- dbg_req  in  1  debug request; held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_W  debug byte address
- dbg_wdata  in  DATA_W  debug write data
- ifu_ack / lsu_ack / dbg_ack  out  1 each  one-cycle completion pulse to the granted requester
- rdata  out  DATA_W  registered read data; valid in the ack cycle
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory Write_data
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  DATA_W  from memory Mem_data (combinational read)
- busy  out  1  high in ACCESS and RESP

## Operation
- FSM with states IDLE, ACCESS and RESP. Encoding is free. Reset state is IDLE.
- IDLE: if any req is high, register the winner in grant and move to ACCESS. Otherwise stay in IDLE.
- Arbitration in IDLE only:
  - dbg has absolute priority.
  - Between ifu and lsu, round-robin on flag last_lsu. If both request, grant ifu when last_lsu = 1, else grant lsu.
  - last_lsu updates on every ifu or lsu grant. A dbg grant leaves it unchanged.
  - last_lsu resets to 1, so ifu wins the first tie.
- ACCESS: the granted port's addr/wdata drive mem_addr/mem_wdata.
  - mem_read = ~we and mem_write = we. The ifu port is always a read.
  - At the closing edge: rdata <= mem_rdata for reads (rdata unchanged for writes), and move to RESP.
  - The memory performs a write at that same edge.
- RESP: assert the granted port's ack for one cycle, then go to IDLE.
- Outside ACCESS: mem_read = mem_write = 0, mem_addr = mem_wdata = 0.
- No preemption. A request arriving during ACCESS/RESP, including dbg, waits for the next IDLE.
- Requesters must drop req at the edge that closes their ack cycle. A req still high in the following IDLE counts as a new request.
- A req dropped before its grant is a protocol violation; behaviour is unspecified.
- Addresses pass through unmodified. Word alignment is the memory's concern.

## Timing
- Reset values: state IDLE, grant none, last_lsu 1, all acks 0, rdata 0, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, busy 0.
- Latency per access:
  - req seen in IDLE cycle T.
  - ACCESS in T+1.
  - ack and rdata valid in T+2.
  - IDLE in T+3.
- Peak throughput is one access per 3 cycles. Back-to-back requests from different ports alternate with a 3-cycle period.
- mem_* outputs are combinational from state/grant and the port inputs. They are glitch-free relative to clk only if port inputs are held stable, which the protocol requires.
- Reset asserted mid-ACCESS or mid-RESP:
  - Immediately forces IDLE and zeroes all outputs, so no ack is issued.
  - A write in flight at the reset edge is not guaranteed.
- Simultaneous requests from all three ports: dbg wins, then ifu/lsu per last_lsu.

## Test plan
- Reset, then ifu_req with ifu_addr=0x0 and the memory holding 0x20042f5b at word 0 -> mem_read=1 and mem_addr=0x0 in T+1; ifu_ack=1 and rdata=0x20042f5b in T+2; busy=0 in T+3.
- lsu store: lsu_we=1, addr=0x80, wdata=0xDEADBEEF, then lsu load from 0x80 -> mem_write=1 for exactly one cycle; the load returns rdata=0xDEADBEEF with lsu_ack.
- ifu_req and lsu_req held continuously from reset -> grant order is ifu, lsu, ifu, lsu; each ack is one cycle; acks are 3 cycles apart.
- dbg_req raised during an lsu ACCESS while ifu_req is also pending -> lsu completes; next grant is dbg; then ifu, since last_lsu=1 is preserved.
- Reset pulsed during the ACCESS of an ifu read -> no ifu_ack; all outputs 0 on the next cycle; FSM in IDLE; a new request completes normally.
- Idle bus, no requests for 20 cycles -> mem_read=mem_write=0, busy=0 and all acks 0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the shared instruction/data memory: grants one of
// dbg/ifu/lsu per access, drives the memory pins for one cycle, then acks.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ifu_req,
  input  logic [ADDR_W-1:0] i_ifu_addr,
  input  logic              i_lsu_req,
  input  logic              i_lsu_we,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [DATA_W-1:0] i_lsu_wdata,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_ifu_ack,
  output logic              o_lsu_ack,
  output logic              o_dbg_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic [1:0]        o_state
);

  // Handshake: a requester raises req with addr/we/wdata stable and holds it
  // until its one-cycle ack. req is sampled only in IDLE, so a req still high
  // in the IDLE after the ack cycle is a new request.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_IFU  = 2'd1,
    G_LSU  = 2'd2,
    G_DBG  = 2'd3
  } grant_t;

  state_t              r_state;
  state_t              w_state_nxt;
  grant_t              r_grant;
  grant_t              w_grant_nxt;
  logic                r_last_lsu;
  logic                w_last_lsu_nxt;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= G_NONE;
      r_last_lsu <= 1'b1;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_last_lsu <= w_last_lsu_nxt;
      if (r_state == S_ACCESS && !w_we) begin
        r_rdata <= i_mem_rdata;
      end
    end
  end

  // dbg wins outright; ifu/lsu ties go to whoever was not granted last.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_lsu_nxt = r_last_lsu;
    case (r_state)
      S_IDLE: begin
        if (i_dbg_req) begin
          w_grant_nxt = G_DBG;
          w_state_nxt = S_ACCESS;
        end else if (i_ifu_req && (!i_lsu_req || r_last_lsu)) begin
          w_grant_nxt    = G_IFU;
          w_last_lsu_nxt = 1'b0;
          w_state_nxt    = S_ACCESS;
        end else if (i_lsu_req) begin
          w_grant_nxt    = G_LSU;
          w_last_lsu_nxt = 1'b1;
          w_state_nxt    = S_ACCESS;
        end
      end
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = G_NONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = G_NONE;
      end
    endcase
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    w_we        = 1'b0;
    if (r_state == S_ACCESS) begin
      case (r_grant)
        G_IFU: o_mem_addr = i_ifu_addr;
        G_LSU: begin
          o_mem_addr  = i_lsu_addr;
          o_mem_wdata = i_lsu_wdata;
          w_we        = i_lsu_we;
        end
        G_DBG: begin
          o_mem_addr  = i_dbg_addr;
          o_mem_wdata = i_dbg_wdata;
          w_we        = i_dbg_we;
        end
        default: w_we = 1'b0;
      endcase
    end
  end

  assign o_mem_read  = (r_state == S_ACCESS) && !w_we;
  assign o_mem_write = (r_state == S_ACCESS) && w_we;
  assign o_ifu_ack   = (r_state == S_RESP) && (r_grant == G_IFU);
  assign o_lsu_ack   = (r_state == S_RESP) && (r_grant == G_LSU);
  assign o_dbg_ack   = (r_state == S_RESP) && (r_grant == G_DBG);
  assign o_rdata     = r_rdata;
  assign o_busy      = (r_state != S_IDLE);
  assign o_state     = r_state;

endmodule
